// File: rtl/spi_ddr_master.sv
// rtl/spi_ddr_master.sv - byte-wide SPI mode-0 master driving a DDR SCK pin word
//
// Purpose: shifts one byte MSB-first on o_mosi while capturing i_miso.
// CS can be held low across bytes for multi-byte flash commands.
// SCK runs at full i_clk rate (DIV=1) or at a divided rate.
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_stb, i_data, i_hold start a byte (taken when o_busy=0), byte, keep-CS flag
//   i_done                release CS from the HELD state
//   o_busy                transfer, CS release or receive capture in progress
//   o_valid, o_rdata      one-cycle received-byte strobe and the byte itself
//   o_cs_n, o_sck_ddr     chip select, DDR clock word ({first half, second half})
//   o_mosi, i_miso        serial data out / in
module spi_ddr_master #(
    parameter int DIV     = 1,
    parameter int RDDELAY = 0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_stb,
    input  logic [7:0] i_data,
    input  logic       i_hold,
    input  logic       i_done,
    output logic       o_busy,
    output logic       o_valid,
    output logic [7:0] o_rdata,
    output logic       o_cs_n,
    output logic [1:0] o_sck_ddr,
    output logic       o_mosi,
    input  logic       i_miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic       hold_q, hold_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] div_q, div_d;
    logic       high_q, high_d;
    logic [7:0] rx_q, rx_d;
    logic [2:0] cap_q, cap_d;
    logic       pend_q, pend_d;
    logic       valid_q, valid_d;
    logic [7:0] rdata_q, rdata_d;

    logic accept;
    logic half_end;
    logic bit_end;
    logic sample;
    logic capture;

    // pend_q keeps o_busy high until the last (possibly delayed) capture lands,
    // so a new byte can never start while the previous one is still arriving.
    assign o_busy   = (state_q inside {ST_SETUP, ST_SHIFT, ST_RELEASE}) || pend_q;
    assign accept   = i_stb && !o_busy && (state_q == ST_IDLE || state_q == ST_HELD);
    assign half_end = (div_q == DIV_LAST);
    // At full rate every cycle is a whole bit; otherwise a bit ends on the
    // last cycle of its high half.
    assign bit_end  = (DIV == 1) ? 1'b1 : (high_q && half_end);
    assign sample   = (state_q == ST_SHIFT) && bit_end;

    generate
        if (RDDELAY == 0) begin : g_nodly
            assign capture = sample;
        end else begin : g_dly
            logic [RDDELAY-1:0] dly_q, dly_d;
            always_comb begin
                dly_d    = dly_q << 1;
                dly_d[0] = sample;
            end
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) dly_q <= '0;
                else            dly_q <= dly_d;
            end
            assign capture = dly_q[RDDELAY-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        div_d   = div_q;
        high_d  = high_q;
        rx_d    = rx_q;
        cap_d   = cap_q;
        pend_d  = pend_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SETUP;
            end
            ST_SETUP: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_end) begin
                    tx_d   = {tx_q[6:0], 1'b0};
                    bit_d  = bit_q + 3'd1;
                    div_d  = 4'd0;
                    high_d = 1'b0;
                    if (bit_q == 3'd7) state_d = hold_q ? ST_HELD : ST_RELEASE;
                end else if (half_end) begin
                    div_d  = 4'd0;
                    high_d = 1'b1;
                end else begin
                    div_d  = div_q + 4'd1;
                end
            end
            ST_HELD: begin
                // CS is already low, so a held byte skips SETUP entirely.
                if (accept)      state_d = ST_SHIFT;
                else if (i_done) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (accept) begin
            tx_d   = i_data;
            hold_d = i_hold;
            pend_d = 1'b1;
            bit_d  = 3'd0;
            div_d  = 4'd0;
            high_d = 1'b0;
        end

        if (capture) begin
            rx_d  = {rx_q[6:0], i_miso};
            cap_d = cap_q + 3'd1;
            if (cap_q == 3'd7) begin
                rdata_d = {rx_q[6:0], i_miso};
                valid_d = 1'b1;
                pend_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            tx_q    <= 8'h00;
            hold_q  <= 1'b0;
            bit_q   <= 3'd0;
            div_q   <= 4'd0;
            high_q  <= 1'b0;
            rx_q    <= 8'h00;
            cap_q   <= 3'd0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            high_q  <= high_d;
            rx_q    <= rx_d;
            cap_q   <= cap_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_rdata   = rdata_q;
    assign o_cs_n    = (state_q == ST_IDLE);
    assign o_mosi    = (state_q == ST_SETUP || state_q == ST_SHIFT) ? tx_q[7] : 1'b0;
    assign o_sck_ddr = (state_q != ST_SHIFT) ? 2'b00 :
                       (DIV == 1)            ? 2'b01 :
                       (high_q ? 2'b11 : 2'b00);

endmodule

// File: tb/tb_spi_ddr_master.sv
// tb/tb_spi_ddr_master.sv - testbench for spi_ddr_master
module tb_spi_ddr_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       stb [3];
    logic       hold [3];
    logic       done [3];
    logic [7:0] data [3];
    logic       busy [3];
    logic       valid [3];
    logic [7:0] rdata [3];
    logic       cs_n [3];
    logic [1:0] sck [3];
    logic       mosi [3];
    logic       miso0, miso1, miso2;
    logic       d1_q, d2_q;

    // u0: full rate, u1: DIV=3, u2: full rate with 2-cycle read delay
    spi_ddr_master #(.DIV(1), .RDDELAY(0)) u0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb[0]), .i_data(data[0]),
        .i_hold(hold[0]), .i_done(done[0]), .o_busy(busy[0]), .o_valid(valid[0]),
        .o_rdata(rdata[0]), .o_cs_n(cs_n[0]), .o_sck_ddr(sck[0]), .o_mosi(mosi[0]),
        .i_miso(miso0));
    spi_ddr_master #(.DIV(3), .RDDELAY(0)) u1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb[1]), .i_data(data[1]),
        .i_hold(hold[1]), .i_done(done[1]), .o_busy(busy[1]), .o_valid(valid[1]),
        .o_rdata(rdata[1]), .o_cs_n(cs_n[1]), .o_sck_ddr(sck[1]), .o_mosi(mosi[1]),
        .i_miso(miso1));
    spi_ddr_master #(.DIV(1), .RDDELAY(2)) u2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb[2]), .i_data(data[2]),
        .i_hold(hold[2]), .i_done(done[2]), .o_busy(busy[2]), .o_valid(valid[2]),
        .o_rdata(rdata[2]), .o_cs_n(cs_n[2]), .o_sck_ddr(sck[2]), .o_mosi(mosi[2]),
        .i_miso(miso2));

    // Loopback slaves; u2's return path has two cycles of pad latency.
    assign miso0 = mosi[0];
    assign miso1 = mosi[1];
    always @(posedge clk) begin
        d1_q <= mosi[2];
        d2_q <= d1_q;
    end
    assign miso2 = d2_q;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] last_rx [3];

    // trace word: {cs_n, sck[1:0], busy, valid, rdata[7:0]}
    logic [12:0] tr_w [64];
    logic [12:0] ex_w [64];
    logic        tr_mosi [64];
    logic        ex_mosi [64];
    logic        ex_mv [64];

    function automatic int div_of(int u);
        return (u == 1) ? 3 : 1;
    endfunction

    function automatic int rd_of(int u);
        return (u == 2) ? 2 : 0;
    endfunction

    // Expected cycle-by-cycle outputs for one byte, t=0 being the first cycle
    // after the accepting edge (SETUP, or first SHIFT cycle when from HELD).
    function automatic void build_exp(int D, int R, logic [7:0] d, logic h, bit held,
                                      logic [7:0] prev, int off);
        int s0, per, len, j;
        logic cs_c, busy_c, valid_c, sh;
        logic [1:0] sck_c;
        logic [7:0] rd_c;
        s0  = held ? 0 : 1;
        per = (D == 1) ? 1 : 2 * D;
        len = 8 * per;
        for (int t = 0; t + off < 64; t++) begin
            j       = t - s0;
            sh      = (t >= s0) && (t < s0 + len);
            sck_c   = !sh ? 2'b00 : (D == 1) ? 2'b01 : ((j % per) >= D ? 2'b11 : 2'b00);
            cs_c    = (t < s0 + len) ? 1'b0 : (h ? 1'b0 : (t == s0 + len ? 1'b0 : 1'b1));
            busy_c  = (t <= s0 + len - 1 + R) || (!h && t == s0 + len);
            valid_c = (t == s0 + len + R);
            rd_c    = (t >= s0 + len + R) ? d : prev;
            ex_w[off + t]    = {cs_c, sck_c, busy_c, valid_c, rd_c};
            ex_mv[off + t]   = (t < s0 + len);
            ex_mosi[off + t] = (t < s0) ? d[7] : (sh ? d[7 - j / per] : 1'b0);
        end
    endfunction

    task automatic start(int u, logic [7:0] d, logic h, logic dn);
        stb[u]  = 1'b1;
        data[u] = d;
        hold[u] = h;
        done[u] = dn;
    endtask

    task automatic record(int u, int n, bit keep, logic [7:0] nd);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            tr_w[t]    = {cs_n[u], sck[u], busy[u], valid[u], rdata[u]};
            tr_mosi[t] = mosi[u];
            if (t == 0) begin
                data[u] = nd;
                if (!keep) begin
                    stb[u]  = 1'b0;
                    done[u] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_free(int u, bit need_idle);
        int k = 0;
        while ((busy[u] !== 1'b0 || (need_idle && cs_n[u] !== 1'b1)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_chk++;
            $display("FAIL wait_free u%0d timeout busy=%b cs_n=%b want busy=0", u, busy[u], cs_n[u]);
        end
    endtask

    task automatic test_reset;
        for (int u = 0; u < 3; u++) begin
            n_chk++;
            if ({cs_n[u], sck[u], busy[u], valid[u], rdata[u], mosi[u]} !== {1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0})
                $display("FAIL reset_state u%0d got cs/sck/busy/valid/rdata/mosi=%b %b %b %b %h %b want 1 00 0 0 00 0",
                         u, cs_n[u], sck[u], busy[u], valid[u], rdata[u], mosi[u]);
            else n_pass++;
        end
    endtask

    task automatic test_basic;
        int ncs, nsck, nval;
        wait_free(0, 1);
        start(0, 8'hA5, 1'b0, 1'b0);
        record(0, 14, 0, 8'hA5);
        build_exp(1, 0, 8'hA5, 1'b0, 0, last_rx[0], 0);
        last_rx[0] = 8'hA5;
        ncs = 0; nsck = 0; nval = 0;
        for (int t = 0; t < 14; t++) begin
            n_chk++;
            if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                $display("FAIL basic t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                         t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
            else n_pass++;
            ncs  += (tr_w[t][12] == 1'b0) ? 1 : 0;
            nsck += (tr_w[t][11:10] == 2'b01) ? 1 : 0;
            nval += tr_w[t][8] ? 1 : 0;
        end
        n_chk++;
        if (ncs !== 10) $display("FAIL basic_cs_low got %0d want 10", ncs); else n_pass++;
        n_chk++;
        if (nsck !== 8) $display("FAIL basic_sck01 got %0d want 8", nsck); else n_pass++;
        n_chk++;
        if (nval !== 1) $display("FAIL basic_valid_count got %0d want 1", nval); else n_pass++;
    endtask

    task automatic test_hold_chain;
        logic [7:0] d3;
        d3 = 8'($urandom);
        wait_free(0, 1);
        start(0, 8'h9F, 1'b1, 1'b0);
        record(0, 11, 0, 8'h9F);
        build_exp(1, 0, 8'h9F, 1'b1, 0, last_rx[0], 0);
        for (int t = 0; t < 11; t++) begin
            n_chk++;
            if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                $display("FAIL hold_b1 t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                         t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
            else n_pass++;
        end
        wait_free(0, 0);
        start(0, 8'h00, 1'b1, 1'b0);
        record(0, 10, 0, 8'h00);
        build_exp(1, 0, 8'h00, 1'b1, 1, 8'h9F, 0);
        for (int t = 0; t < 10; t++) begin
            n_chk++;
            if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                $display("FAIL hold_b2 t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                         t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
            else n_pass++;
        end
        n_chk++;
        if (tr_w[0][11:10] !== 2'b01) $display("FAIL hold_no_setup got sck=%b want 01", tr_w[0][11:10]);
        else n_pass++;
        wait_free(0, 0);
        start(0, d3, 1'b1, 1'b1);
        record(0, 10, 0, d3);
        build_exp(1, 0, d3, 1'b1, 1, 8'h00, 0);
        for (int t = 0; t < 10; t++) begin
            n_chk++;
            if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                $display("FAIL hold_stb_done t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                         t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
            else n_pass++;
        end
        done[0] = 1'b1;
        record(0, 3, 0, d3);
        last_rx[0] = d3;
        n_chk++;
        if (tr_w[0] !== {1'b0, 2'b00, 1'b1, 1'b0, d3})
            $display("FAIL hold_release got word=%h want %h", tr_w[0], {1'b0, 2'b00, 1'b1, 1'b0, d3});
        else n_pass++;
        for (int t = 1; t < 3; t++) begin
            n_chk++;
            if (tr_w[t] !== {1'b1, 2'b00, 1'b0, 1'b0, d3})
                $display("FAIL hold_idle t=%0d got word=%h want %h", t, tr_w[t], {1'b1, 2'b00, 1'b0, 1'b0, d3});
            else n_pass++;
        end
    endtask

    task automatic test_div3;
        int nhi, nmosi;
        wait_free(1, 1);
        start(1, 8'h80, 1'b0, 1'b0);
        record(1, 52, 0, 8'h80);
        build_exp(3, 0, 8'h80, 1'b0, 0, last_rx[1], 0);
        last_rx[1] = 8'h80;
        nhi = 0; nmosi = 0;
        for (int t = 0; t < 52; t++) begin
            n_chk++;
            if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                $display("FAIL div3 t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                         t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
            else n_pass++;
            nhi += (tr_w[t][11:10] == 2'b11) ? 1 : 0;
            if (t >= 1 && t <= 48) nmosi += tr_mosi[t] ? 1 : 0;
        end
        n_chk++;
        if (nhi !== 24) $display("FAIL div3_sck_high got %0d want 24", nhi); else n_pass++;
        n_chk++;
        if (nmosi !== 6) $display("FAIL div3_mosi_high got %0d want 6", nmosi); else n_pass++;
    endtask

    task automatic test_rddelay;
        wait_free(2, 1);
        start(2, 8'h3C, 1'b0, 1'b0);
        record(2, 14, 0, 8'h3C);
        build_exp(1, 2, 8'h3C, 1'b0, 0, last_rx[2], 0);
        last_rx[2] = 8'h3C;
        for (int t = 0; t < 14; t++) begin
            n_chk++;
            if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                $display("FAIL rddelay t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                         t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
            else n_pass++;
        end
        n_chk++;
        if (tr_w[11][8] !== 1'b1 || tr_w[12][7:0] !== 8'h3C)
            $display("FAIL rddelay_valid got valid@11=%b rdata@12=%h want 1 3c", tr_w[11][8], tr_w[12][7:0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] da, db;
        da = 8'($urandom);
        db = ~da;
        wait_free(0, 1);
        start(0, da, 1'b0, 1'b0);
        record(0, 22, 1, db);
        stb[0] = 1'b0;
        build_exp(1, 0, da, 1'b0, 0, last_rx[0], 0);
        build_exp(1, 0, db, 1'b0, 0, da, 11);
        last_rx[0] = db;
        for (int t = 0; t < 22; t++) begin
            n_chk++;
            if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                $display("FAIL back_to_back t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                         t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        int u, n, per;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            u   = int'($urandom_range(0, 2));
            d   = 8'($urandom);
            per = (div_of(u) == 1) ? 1 : 2 * div_of(u);
            n   = 1 + 8 * per + rd_of(u) + 3;
            wait_free(u, 1);
            start(u, d, 1'b0, 1'b0);
            record(u, n, 0, d);
            build_exp(div_of(u), rd_of(u), d, 1'b0, 0, last_rx[u], 0);
            last_rx[u] = d;
            for (int t = 0; t < n; t++) begin
                n_chk++;
                if (tr_w[t] !== ex_w[t] || (ex_mv[t] && tr_mosi[t] !== ex_mosi[t]))
                    $display("FAIL random u%0d d=%h t=%0d got word=%h mosi=%b want word=%h mosi=%b",
                             u, d, t, tr_w[t], tr_mosi[t], ex_w[t], ex_mosi[t]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        int nval, ncs;
        logic [7:0] d;
        d = 8'($urandom) | 8'h01;
        wait_free(0, 1);
        start(0, d, 1'b0, 1'b0);
        record(0, 4, 0, d);
        n_chk++;
        if (tr_w[3][12:10] !== 3'b001) $display("FAIL reset_mid_inshift got cs/sck=%b want 001", tr_w[3][12:10]);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cs_n[0], sck[0], busy[0], valid[0], rdata[0]} !== {1'b1, 2'b00, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset_mid_now got cs/sck/busy/valid/rdata=%b %b %b %b %h want 1 00 0 0 00",
                     cs_n[0], sck[0], busy[0], valid[0], rdata[0]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        nval = 0; ncs = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            nval += valid[0] ? 1 : 0;
            ncs  += (cs_n[0] == 1'b0) ? 1 : 0;
        end
        n_chk++;
        if (nval !== 0 || ncs !== 0) $display("FAIL reset_mid_after got valid=%0d cs_low=%0d want 0 0", nval, ncs);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            stb[u] = 1'b0; hold[u] = 1'b0; done[u] = 1'b0; data[u] = 8'h00; last_rx[u] = 8'h00;
        end
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_basic;
        test_hold_chain;
        test_div3;
        test_rddelay;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_ddr_master.md
Name: spi_ddr_master

Overview:
- Byte-wide SPI mode-0 master for the iCE40 serial flash port.
- Drives the two-bit DDR clock word into the DDR output clock pin driver; bit [1] goes out in the first half of each i_clk cycle, bit [0] in the second half.
- Also drives MOSI and CS_n, and captures MISO.
- Runs SCK at full i_clk rate (DIV=1) or divided rate; supports holding CS across bytes for multi-byte flash commands.

Parameters:
- DIV, 1: SCK half-period in i_clk cycles when >1. DIV=1 selects full-rate DDR clocking, one bit per i_clk. Legal range 1..16.
- RDDELAY, 0: extra i_clk cycles between nominal MISO sample point and actual capture; absorbs pad/IO register latency. Legal range 0..3.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_stb  in  1  start byte transfer; accepted only when o_busy=0
- i_data  in  8  byte to transmit, MSB first; sampled on accept
- i_hold  in  1  sampled on accept; 1 = keep CS low after this byte
- i_done  in  1  in HELD state, release CS
- o_busy  out  1  transfer or CS release in progress
- o_valid  out  1  one-cycle pulse: o_rdata holds a new received byte
- o_rdata  out  8  received byte, MSB first; holds until next o_valid
- o_cs_n  out  1  flash chip select, active low
- o_sck_ddr  out  2  DDR clock word to the clock pin driver
- o_mosi  out  1  serial data out
- i_miso  in  1  serial data in

Behaviour:
- Reset (async, immediate, any state): state=IDLE, o_cs_n=1, o_sck_ddr=2'b00, o_mosi=0, o_busy=0, o_valid=0, o_rdata=8'h00.
- States: IDLE, SETUP, SHIFT, HELD, RELEASE.
- Outside SHIFT, o_sck_ddr=2'b00 (SCK idles low).
- IDLE:
  - i_stb → SETUP on next edge, latch i_data/i_hold.
  - o_busy=1 and o_cs_n=0 from the following cycle.
- SETUP: one cycle. o_cs_n=0, o_mosi=i_data[7], SCK idle. Next state SHIFT.
- SHIFT: 8 bits, k=7..0, MSB first.
  - DIV=1: each bit is one cycle with o_sck_ddr=2'b01, so SCK rises mid-cycle. o_mosi=bit k for the whole cycle.
  - DIV>1: each bit is 2*DIV cycles: DIV cycles of 2'b00, then DIV cycles of 2'b11. o_mosi is stable for all 2*DIV cycles.
  - o_mosi changes only at bit boundaries, i.e. on the SCK falling edge.
  - Nominal sample point for bit k: the i_clk edge ending its last high cycle. i_miso is captured RDDELAY cycles after that edge.
- After the 8th bit's last cycle:
  - i_hold=1 → HELD.
  - i_hold=0 → RELEASE.
- HELD:
  - o_cs_n=0, o_busy=0.
  - i_stb → SHIFT directly (no SETUP), o_mosi=new bit 7 next cycle.
  - i_done with no i_stb → RELEASE.
  - i_stb and i_done together: i_stb wins.
- RELEASE: one cycle, o_cs_n=0, o_busy=1. Then IDLE with o_cs_n=1.
- o_valid:
  - Pulses one cycle, the cycle after the 8th capture; o_rdata updates on the same edge.
  - With RDDELAY>0 the pulse may occur while in HELD, RELEASE or IDLE.
  - o_busy stays 1 until o_valid has pulsed. A new i_stb is accepted only once o_busy=0.
- i_stb while o_busy=1: ignored, no state change.
- Bit counter wraps never: exactly 8 bits per accepted strobe. DIV counter reloads each half-bit.
- Reset mid-transfer: CS rises immediately; partial byte discarded; no o_valid.

Test Plan:
- Reset: hold i_reset_n=0 mid-SHIFT → same cycle o_cs_n=1, o_sck_ddr=00, o_busy=0, o_valid=0, o_rdata=00; no o_valid after release.
- DIV=1, RDDELAY=0, MISO looped to MOSI, i_stb with i_data=0xA5, i_hold=0:
  - o_cs_n low 10 cycles (SETUP + 8 SHIFT + RELEASE).
  - o_sck_ddr=01 exactly 8 cycles.
  - o_mosi = 1,0,1,0,0,1,0,1.
  - o_valid once with o_rdata=0xA5.
- Hold chain: 0x9F with i_hold=1, then i_stb 0x00 while in HELD:
  - CS never rises between bytes; no SETUP cycle before the second byte.
  - i_done → one RELEASE cycle, then o_cs_n=1.
- DIV=3: send 0x80 → each bit spans 6 cycles (3×00 then 3×11), 48 SHIFT cycles total; o_mosi high only during the first 6.
- RDDELAY=2 with a bench model delaying MISO by 2 cycles, slave returns 0x3C → o_rdata=0x3C; o_valid 3 cycles after last SHIFT cycle.
- i_stb asserted every cycle during a transfer → only the first byte is sent; next accept occurs the cycle o_busy=0.
